et_trace_sequencer: RTL
=======================

Name: et_trace_sequencer

Overview:
- Sequencer that replays a stored per-cycle bitvector trace into a property-monitor DUT (e.g. NOI) and collects its verdict.
- Phases: DUT reset, trace steps, drain idle cycles; first violation is captured.
- Sits between a trace loader (bench or host) and the monitor under test. Replaces the hand-written repeat/assign sequences in the execution benches.

Parameters:
- MAX_STEPS, 16, trace memory depth in steps.
- N_SIG, 2, signals driven per step (bit 0 = a, bit 1 = b).
- RESET_CYCLES, 2, cycles dut_reset is held high per run (min 1).
- DRAIN_CYCLES, 2, zero-stimulus cycles after the last step (min 0).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  trace memory write strobe.
- wr_addr  in  AW=$clog2(MAX_STEPS)  write address.
- wr_data  in  N_SIG  step vector to store.
- len  in  AW+1  number of steps to replay; sampled on start.
- start  in  1  run request.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- dut_reset  out  1  reset to the monitor DUT.
- dut_sig  out  N_SIG  stimulus to the monitor DUT.
- step_idx  out  AW  index of the step currently on dut_sig.
- violation  in  1  monitor failure flag.
- fail  out  1  sticky: a violation was seen this run.
- fail_step  out  AW+1  step index at first violation; drain cycles report len.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- All outputs are registered.
- Reset values: busy=0, done=0, dut_reset=1, dut_sig=0, step_idx=0, fail=0, fail_step=0, state=IDLE.
- Trace memory contents are not reset.
- FSM states: IDLE, RST, RUN, DRAIN, DONE.
- IDLE: dut_reset=1, dut_sig=0.
  - start=1 -> RST next cycle.
  - Latch eff_len = min(len, MAX_STEPS).
  - Clear fail and fail_step.
- RST: dut_reset=1, dut_sig=0 for exactly RESET_CYCLES cycles.
  - Exit to RUN if eff_len>0.
  - Otherwise exit to DRAIN, or DONE if DRAIN_CYCLES=0.
- RUN: dut_reset=0, dut_sig=mem[k], step_idx=k, for k=0..eff_len-1, one cycle each.
  - Exit to DRAIN, or DONE if DRAIN_CYCLES=0.
- DRAIN: dut_reset=0, dut_sig=0 for DRAIN_CYCLES cycles, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - fail and fail_step hold until the next accepted start.
- Latency: start at edge t gives dut_reset=1 over cycles t+1..t+RESET_CYCLES.
  - First step appears at cycle t+RESET_CYCLES+1.
  - done at cycle t+RESET_CYCLES+eff_len+DRAIN_CYCLES+1.
- busy=1 in RST, RUN, DRAIN and DONE.
- start while busy is ignored.
- wr_en is honoured only in IDLE; writes while busy are dropped.
- violation is sampled only in RUN and DRAIN.
  - First violation sets fail=1 and fail_step = k in RUN, or eff_len in DRAIN.
  - Later violations are ignored.
- Simultaneous wr_en and start in IDLE: the write completes and the run reads the new data.
- len > MAX_STEPS is clamped. len=0 gives a run with no stimulus steps.
- step_idx does not wrap; it stays at its last value through DRAIN and DONE.
- reset asserted mid-run: next cycle IDLE with all outputs at reset values, dut_reset=1.

Optional Feature:
- Macro: ET_FAIL_STOP_EN.
- Defined: the first violation in RUN aborts remaining steps.
  - Next cycle enters DRAIN (or DONE if DRAIN_CYCLES=0).
  - fail_step is recorded as normal.
- Undefined: the full trace always replays regardless of violation.

Decomposition:
- Package et_seq_pkg:
  - state enum et_seq_state_e {IDLE, RST, RUN, DRAIN, DONE}.
  - Default parameter constants.
  - Helper function clamp_len.
- Sub-module et_trace_mem: MAX_STEPS x N_SIG register file with one synchronous write port and one combinational read port.
- The FSM and counters stay in et_trace_sequencer.

Test Plan:
- Load 4 steps {00,01,10,11}, len=4, start, violation=0 -> dut_reset high 2 cycles, dut_sig 00,01,10,11 on consecutive cycles, 2 zero cycles, done after 9 cycles, fail=0.
- Load 10 steps all 00, len=10, violation pulsed at step 6 and at step 8 -> fail=1, fail_step=6.
  - With ET_FAIL_STOP_EN: DRAIN entered after step 6, done 3 cycles earlier than without.
- len=0, start -> 2 reset cycles, 2 drain cycles, done, dut_sig=0 throughout.
- len=20 with MAX_STEPS=16 -> exactly 16 steps replayed, step_idx ends at 15.
- start and wr_en pulsed during RUN -> ignored; memory unchanged, run length unchanged.
- reset asserted during RUN step 2 -> next cycle IDLE, busy=0, dut_reset=1, dut_sig=0, fail=0, no done pulse.

Source files
------------

// File: rtl/et_trace_sequencer_pkg.sv
// Shared types, default parameters and helpers for the trace sequencer.
package et_seq_pkg;
  typedef enum logic [2:0] {IDLE, RST, RUN, DRAIN, DONE} et_seq_state_e;

  localparam int ET_MAX_STEPS     = 16;
  localparam int ET_N_SIG         = 2;
  localparam int ET_RESET_CYCLES  = 2;
  localparam int ET_DRAIN_CYCLES  = 2;

  function automatic int clamp_len(input int len, input int max_steps);
    return (len > max_steps) ? max_steps : len;
  endfunction
endpackage

// File: rtl/et_trace_sequencer_if.sv
// Loader/monitor-facing signal bundle of the trace sequencer.
interface et_trace_sequencer_if #(
  parameter int MAX_STEPS = 16,
  parameter int N_SIG     = 2
);
  localparam int AW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [N_SIG-1:0] wr_data;
  logic [AW:0]      len;
  logic             start;
  logic             busy;
  logic             done;
  logic             dut_reset;
  logic [N_SIG-1:0] dut_sig;
  logic [AW-1:0]    step_idx;
  logic             violation;
  logic             fail;
  logic [AW:0]      fail_step;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, violation,
    input  busy, done, dut_reset, dut_sig, step_idx, fail, fail_step
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, violation,
    output busy, done, dut_reset, dut_sig, step_idx, fail, fail_step
  );
endinterface

// File: rtl/et_trace_sequencer_mem.sv
// Trace storage: MAX_STEPS x N_SIG registers, synchronous write, combinational read.
module et_trace_mem #(
  parameter int MAX_STEPS = 16,
  parameter int N_SIG     = 2,
  parameter int AW        = 4
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [N_SIG-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [N_SIG-1:0] rd_data
);
  logic [N_SIG-1:0] mem [MAX_STEPS];

  always_ff @(posedge clock) begin
    if (wr_en && (int'(wr_addr) < MAX_STEPS)) mem[wr_addr] <= wr_data;
  end

  assign rd_data = (int'(rd_addr) < MAX_STEPS) ? mem[rd_addr] : '0;
endmodule

// File: rtl/et_trace_sequencer.sv
// Replays a stored trace into a property monitor and captures its first violation.
// Optional ET_FAIL_STOP_EN: the first violation during RUN aborts the remaining steps.
//   state | meaning
//   IDLE  | monitor held in reset, trace writes accepted, waiting for start
//   RST   | monitor reset for RESET_CYCLES cycles
//   RUN   | one stored step per cycle on dut_sig
//   DRAIN | DRAIN_CYCLES zero-stimulus cycles
//   DONE  | one-cycle done pulse
module et_trace_sequencer
  import et_seq_pkg::*;
#(
  parameter int MAX_STEPS    = ET_MAX_STEPS,
  parameter int N_SIG        = ET_N_SIG,
  parameter int RESET_CYCLES = ET_RESET_CYCLES,
  parameter int DRAIN_CYCLES = ET_DRAIN_CYCLES
) (
  input logic clock,
  input logic reset,
  et_trace_sequencer_if.slave bus
);
  localparam int AW   = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int LW   = AW + 1;
  localparam int CMAX = (RESET_CYCLES > MAX_STEPS)
                        ? ((RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES)
                        : ((MAX_STEPS > DRAIN_CYCLES) ? MAX_STEPS : DRAIN_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  et_seq_state_e    state;
  logic [CW-1:0]    cnt;
  logic [LW-1:0]    eff_len;
  logic             busy, done, dut_reset, fail;
  logic [N_SIG-1:0] dut_sig;
  logic [AW-1:0]    step_idx;
  logic [LW-1:0]    fail_step;
  logic [AW-1:0]    rd_addr;
  logic [N_SIG-1:0] rd_data;
  logic             mem_we, hit, abort;

  // Read port looks one step ahead so dut_sig can be registered.
  assign rd_addr = (state == RUN) ? step_idx + AW'(1) : '0;
  assign mem_we  = bus.wr_en && (state == IDLE);
  assign hit     = bus.violation && !fail;
`ifdef ET_FAIL_STOP_EN
  assign abort   = hit;
`else
  assign abort   = 1'b0;
`endif

  et_trace_mem #(.MAX_STEPS(MAX_STEPS), .N_SIG(N_SIG), .AW(AW)) u_mem (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      eff_len   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_reset <= 1'b1;
      dut_sig   <= '0;
      step_idx  <= '0;
      fail      <= 1'b0;
      fail_step <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          state     <= RST;
          busy      <= 1'b1;
          eff_len   <= LW'(clamp_len(int'(bus.len), MAX_STEPS));
          fail      <= 1'b0;
          fail_step <= '0;
          step_idx  <= '0;
          cnt       <= CW'(RESET_CYCLES - 1);
        end
        RST: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (eff_len != '0) begin
            state     <= RUN;
            dut_reset <= 1'b0;
            dut_sig   <= rd_data;
            step_idx  <= '0;
            cnt       <= CW'(eff_len - LW'(1));
          end else if (DRAIN_CYCLES > 0) begin
            state     <= DRAIN;
            dut_reset <= 1'b0;
            cnt       <= CW'(DRAIN_CYCLES - 1);
          end else begin
            state     <= DONE;
            dut_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        RUN: begin
          if (hit) begin
            fail      <= 1'b1;
            fail_step <= LW'(step_idx);
          end
          if (cnt == '0 || abort) begin
            dut_sig <= '0;
            if (DRAIN_CYCLES > 0) begin
              state <= DRAIN;
              cnt   <= CW'(DRAIN_CYCLES - 1);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            step_idx <= step_idx + AW'(1);
            dut_sig  <= rd_data;
            cnt      <= cnt - CW'(1);
          end
        end
        DRAIN: begin
          if (hit) begin
            fail      <= 1'b1;
            fail_step <= eff_len;
          end
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          dut_reset <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.dut_reset = dut_reset;
  assign bus.dut_sig   = dut_sig;
  assign bus.step_idx  = step_idx;
  assign bus.fail      = fail;
  assign bus.fail_step = fail_step;
endmodule
